// File: rtl/spi_master_ctrl_if.sv
// Host and pin-side signal bundle for the SPI master controller.
// The master modport is the controller's view; slave is the host/peripheral side.
interface spi_master_ctrl_if;
    logic       start;
    logic [9:0] cmd;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, cmd, MISO,
        output busy, done, rd_data, rd_valid, SS_n, MOSI
    );

    modport slave (
        output start, cmd, MISO,
        input  busy, done, rd_data, rd_valid, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: frames one 10-bit command per transaction on SS_n/MOSI
// (SCK = clk) and captures an 8-bit MISO reply for read-data commands.
module spi_master_ctrl #(
    parameter int RD_LAT = 3,  // edges from last MOSI-sampled edge to first MISO sample (1..15)
    parameter int GAP    = 1   // SS_n high cycles after a frame before a new start (1..15)
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_SEL      = 3'd2;
    localparam logic [2:0] S_SHIFT    = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_SHIFT = 3'd5;
    localparam logic [2:0] S_GAP      = 3'd6;

    logic [2:0] state;
    logic [9:0] cmd_q;
    logic [3:0] cnt;         // bit index while shifting, latency/gap count otherwise
    logic       shift_last;  // cmd_q[0] is on MOSI; next edge closes the command phase
    logic [6:0] rx_sr;
    logic       accept;

    // The final GAP edge doubles as the IDLE sampling edge, so a held start
    // yields frames separated by exactly GAP cycles of SS_n high.
    assign accept = bus.start &&
                    ((state == S_IDLE) || ((state == S_GAP) && (cnt == 4'd1)));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_q      <= '0;
            cnt        <= '0;
            shift_last <= 1'b0;
            rx_sr      <= '0;
            bus.SS_n     <= 1'b1;
            bus.MOSI     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= 8'h00;
        end else if (accept) begin
            state        <= S_SETUP;
            cmd_q        <= bus.cmd;
            bus.SS_n     <= 1'b0;
            bus.MOSI     <= 1'b0;
            bus.busy     <= 1'b1;
            bus.done     <= 1'b0;
            bus.rd_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.busy <= 1'b0;
                end
                S_SETUP: begin
                    // Path-select bit goes out one edge early for the slave's command check.
                    bus.MOSI <= cmd_q[9];
                    state    <= S_SEL;
                end
                S_SEL: begin
                    bus.MOSI   <= cmd_q[9];
                    cnt        <= 4'd8;
                    shift_last <= 1'b0;
                    state      <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!shift_last) begin
                        bus.MOSI   <= cmd_q[cnt];
                        shift_last <= (cnt == 4'd0);
                        cnt        <= cnt - 4'd1;
                    end else begin
                        bus.MOSI   <= 1'b0;
                        shift_last <= 1'b0;
                        if (cmd_q[9:8] == 2'b11) begin
                            if (RD_LAT == 1) begin
                                cnt   <= 4'd7;
                                state <= S_RD_SHIFT;
                            end else begin
                                cnt   <= 4'(RD_LAT - 1);
                                state <= S_RD_WAIT;
                            end
                        end else begin
                            bus.SS_n <= 1'b1;
                            bus.done <= 1'b1;
                            cnt      <= 4'(GAP);
                            state    <= S_GAP;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd7;
                        state <= S_RD_SHIFT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RD_SHIFT: begin
                    rx_sr <= {rx_sr[5:0], bus.MISO};
                    if (cnt == 4'd0) begin
                        bus.SS_n     <= 1'b1;
                        bus.rd_data  <= {rx_sr, bus.MISO};
                        bus.rd_valid <= 1'b1;
                        bus.done     <= 1'b1;
                        cnt          <= 4'(GAP);
                        state        <= S_GAP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_GAP: begin
                    bus.done     <= 1'b0;
                    bus.rd_valid <= 1'b0;
                    if (cnt == 4'd1) begin
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    bus.SS_n <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboarded bench for spi_master_ctrl: a closed-loop SPI slave + RAM drives MISO,
// a transaction-level reference model predicts every frame the monitor observes.
module tb_spi_master_ctrl;

    localparam int RD_LAT = 3;
    localparam int GAP    = 1;
    localparam int WR_LEN = 12;
    localparam int RD_LEN = 12 + RD_LAT + 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_master_ctrl_if bus ();

    spi_master_ctrl #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;  // number of rising edges so far; stable when read at negedge
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] cmd;
        int         acc;   // edge number where the frame is accepted
        int         len;   // SS_n-low cycles
        logic       rv;
        logic [7:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Transaction-level reference: the RAM behind the slave, as the host sees it.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_wa, ref_ra, ref_last_rd;

    // Pin-level slave model state.
    logic [7:0] s_mem [256];
    logic [7:0] s_wa, s_ra, s_reply;
    logic [9:0] s_cmd;
    logic       s_rd;
    int         s_k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int frame_len(input logic [9:0] c);
        return (c[9:8] == 2'b11) ? RD_LEN : WR_LEN;
    endfunction

    function automatic void model_push(input logic [9:0] c, input int acc);
        exp_t e;
        case (c[9:8])
            2'b00: ref_wa = c[7:0];
            2'b01: ref_mem[ref_wa] = c[7:0];
            2'b10: ref_ra = c[7:0];
            default: ref_last_rd = ref_mem[ref_ra];
        endcase
        e.cmd = c;
        e.acc = acc;
        e.len = frame_len(c);
        e.rv  = (c[9:8] == 2'b11);
        e.rd  = ref_last_rd;
        sb_q.push_back(e);
    endfunction

    // Leaves the caller at a negedge with busy low.
    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (bus.busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic send(input logic [9:0] c, input bit poke);
        int acc;
        wait_idle();
        bus.start = 1'b1;
        bus.cmd   = c;
        acc       = cyc + 1;
        model_push(c, acc);
        @(negedge clk);
        bus.start = 1'b0;
        bus.cmd   = 10'($urandom);
        if (poke) begin
            repeat (4) @(negedge clk);
            bus.start = 1'b1;  // sampled at E5: must be ignored
            bus.cmd   = 10'($urandom);
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic send_b2b(input logic [9:0] c1, input logic [9:0] c2);
        int acc1, acc2;
        wait_idle();
        bus.start = 1'b1;
        bus.cmd   = c1;
        acc1      = cyc + 1;
        acc2      = acc1 + frame_len(c1) + GAP;
        model_push(c1, acc1);
        model_push(c2, acc2);
        @(negedge clk);
        bus.cmd = 10'($urandom);
        while (cyc < acc2 - 1) @(negedge clk);
        bus.cmd = c2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.cmd   = 10'($urandom);
    endtask

    task automatic reset_mid_frame(input logic [9:0] c);
        wait_idle();
        bus.start = 1'b1;
        bus.cmd   = c;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ss_n", 32'(bus.SS_n), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h00);
        ref_last_rd = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Slave + RAM: decodes each frame from MOSI and answers rd-data from its RAM.
    initial begin
        bus.MISO = 1'b0;
        s_k = 0;
        s_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || bus.SS_n) begin
                s_k      = 0;
                s_rd     = 1'b0;
                bus.MISO = 1'($urandom);
            end else begin
                if (s_k >= 2 && s_k <= 11) s_cmd = {s_cmd[8:0], bus.MOSI};
                if (s_k == 11) begin
                    case (s_cmd[9:8])
                        2'b00: s_wa = s_cmd[7:0];
                        2'b01: s_mem[s_wa] = s_cmd[7:0];
                        2'b10: s_ra = s_cmd[7:0];
                        default: begin
                            s_reply = s_mem[s_ra];
                            s_rd    = 1'b1;
                        end
                    endcase
                end
                if (s_rd && s_k >= 11 + RD_LAT && s_k <= 18 + RD_LAT)
                    bus.MISO = s_reply[7 - (s_k - (11 + RD_LAT))];
                else
                    bus.MISO = 1'($urandom);
                s_k++;
            end
        end
    end

    // Monitor: rebuilds each frame from the pins and checks it against the scoreboard.
    initial begin
        bit          in_frame = 1'b0;
        int          k = 0, first_cyc = 0, tail = 0;
        logic [11:0] mosi_rec = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
            end else if (in_frame && bus.SS_n) begin
                in_frame = 1'b0;
                if (sb_q.size() == 0) begin
                    check("frame_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("start_cycle", 32'(first_cyc), 32'(e.acc));
                    check("frame_len", 32'(k), 32'(e.len));
                    check("mosi_bits", 32'(mosi_rec), 32'({1'b0, e.cmd[9], e.cmd}));
                    check("mosi_tail", 32'(tail), 32'd0);
                    check("done", 32'(bus.done), 32'd1);
                    check("rd_valid", 32'(bus.rd_valid), 32'(e.rv));
                    check("rd_data", 32'(bus.rd_data), 32'(e.rd));
                end
            end else begin
                if (bus.done) check("spurious_done", 32'(bus.done), 32'd0);
                if (bus.rd_valid) check("spurious_rd_valid", 32'(bus.rd_valid), 32'd0);
                if (!in_frame && !bus.SS_n) begin
                    in_frame  = 1'b1;
                    first_cyc = cyc;
                    k         = 0;
                    tail      = 0;
                    mosi_rec  = '0;
                end
                if (in_frame) begin
                    if (k < 12) mosi_rec = {mosi_rec[10:0], bus.MOSI};
                    else tail += int'(bus.MOSI);
                    k++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] c1, c2;
        int         mode;
        bus.start = 1'b0;
        bus.cmd   = '0;
        ref_wa = '0; ref_ra = '0; ref_last_rd = '0;
        s_wa = '0; s_ra = '0; s_reply = '0; s_cmd = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i * 7 + 3);
            s_mem[i]   = 8'(i * 7 + 3);
        end

        #12;
        check("reset_ss_n", 32'(bus.SS_n), 32'd1);
        check("reset_mosi", 32'(bus.MOSI), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("reset_rd_data", 32'(bus.rd_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        send(10'b00_1010_0101, 1'b0);
        send(10'b00_0000_0000, 1'b0);
        send(10'b01_1100_0011, 1'b0);
        send(10'b10_0000_0000, 1'b0);
        send(10'b11_0000_0000, 1'b0);   // reply 8'hC3

        reset_mid_frame(10'b00_1111_1111);

        send(10'b01_0110_0110, 1'b1);    // start pulsed mid-frame
        send_b2b(10'b00_0011_0001, 10'b01_1110_0111);
        send_b2b(10'b11_0000_0000, 10'b10_0000_0011);

        send(10'b00_0001_0010, 1'b0);
        send(10'b01_0101_1010, 1'b0);
        send(10'b10_0001_0010, 1'b0);
        send(10'b11_0000_0000, 1'b0);   // reply 8'h5A

        for (int n = 0; n < 40; n++) begin
            c1   = {2'($urandom_range(0, 3)), 8'($urandom)};
            c2   = {2'($urandom_range(0, 3)), 8'($urandom)};
            if (c1[9:8] != 2'b01) c1[7:0] = 8'($urandom_range(0, 7));
            if (c2[9:8] != 2'b01) c2[7:0] = 8'($urandom_range(0, 7));
            mode = $urandom_range(0, 3);
            if (mode == 0)      send_b2b(c1, c2);
            else if (mode == 1) send(c1, 1'b1);
            else                send(c1, 1'b0);
        end

        wait_idle();
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
